simon_frame_sequencer: RTL and testbench
========================================

// Module: simon_frame_sequencer
// PURPOSE
//  Controller in front of the Simon 32/64 round datapath. Collects a frame of serial key
//  bytes and plaintext nibbles over a valid/ready handshake and loads the round core.
//  Sequences the core through all rounds, then streams the ciphertext back out nibble by nibble.
//  Sits between the chip pads and the round core, inside the top level.
// PARAMETERS
//  KW      8   key bits per input beat
//  PW      4   plaintext/cipher bits per beat
//  BEATS   8   beats per frame (key = KW*BEATS = 64b, block = PW*BEATS = 32b)
//  ROUNDS  32  round-enable cycles issued per frame
//  RW      5   width of round index, must satisfy 2**RW >= ROUNDS
// PORTS
//  clk         in   1        system clock, rising edge
//  reset       in   1        asynchronous, active-low (0 = reset)
//  start       in   1        frame marker, qualifies beat 0 of a frame
//  in_valid    in   1        key/Plaintxt beat valid
//  in_ready    out  1        sequencer accepts a beat this cycle
//  key         in   KW       key beat, big-endian (first beat = key_word[63:56])
//  Plaintxt    in   PW       plaintext beat, big-endian (first beat = blk_word[31:28])
//  key_word    out  KW*BEATS assembled key to round core
//  blk_word    out  PW*BEATS assembled plaintext to round core
//  core_load   out  1        one-cycle load strobe to round core
//  core_rnd_en out  1        round core advances one round
//  core_round  out  RW       index of the round being executed
//  core_ct     in   PW*BEATS ciphertext from round core
//  out_valid   out  1        cipher nibble valid
//  out_ready   in   1        downstream accepts nibble
//  cipher      out  PW       cipher nibble, MS nibble first
//  done_final  out  1        one-cycle pulse, frame complete
//  busy        out  1        high in every state except LOAD
// BEHAVIOUR
//  Reset values: all outputs 0. key_word, blk_word, beat counter, round counter and out shift register are 0. State = LOAD.
//  Beat accepted when in_valid && in_ready. The accepted key beat shifts into the LSB of key_word and Plaintxt shifts into the LSB of blk_word.
//  LOAD: in_ready=1, beat_cnt 0..BEATS-1.
//   - A beat with start=0 while beat_cnt==0 is dropped. It is not captured and does not advance the counter.
//   - A beat with start=1 at any beat_cnt restarts the frame. It is captured as beat 0 and beat_cnt becomes 1, discarding the partial frame.
//   - Accepting beat BEATS-1 moves to KICK.
//  KICK (1 cycle): core_load=1, in_ready=0. key_word and blk_word are held stable from here until the next LOAD capture.
//  ROUND: core_rnd_en=1 for exactly ROUNDS consecutive cycles, with core_round = 0,1,..,ROUNDS-1. After the last round, go to CAPTURE.
//  CAPTURE (1 cycle): core_ct is registered into the output shift register, then go to DRAIN.
//  DRAIN: out_valid=1 and cipher = shreg MS nibble.
//   - On out_valid && out_ready, shift left by PW.
//   - out_valid is held while out_ready=0. cipher must not change while stalled.
//   - The handshake that accepts nibble BEATS-1 causes done_final=1 on the next cycle, in the same cycle the state returns to LOAD (in_ready=1).
//  Latency: from the edge accepting the last input beat to the first out_valid is ROUNDS+2 cycles (34 at defaults).
//  in_ready=0 in KICK, ROUND, CAPTURE and DRAIN. Inputs are never buffered, and no new frame overlaps a frame in flight.
//  start/in_valid outside LOAD are ignored. out_ready outside DRAIN is ignored.
//  Reset asserted mid-frame, in any state, clears everything to reset values immediately. No done_final is issued for that frame.
// TESTING
//  1 Frame with key 19,18,11,10,09,08,01,00 and pt 6,5,6,5,6,8,7,7 (start=1 on beat 0) is loaded.
//    -> key_word=1918111009080100 and blk_word=65656877 at core_load.
//    -> The Simon round core returns c69be9bb, so cipher = c,6,9,b,e,9,b,b and done_final pulses once.
//  2 Latency check with out_ready=1 throughout. -> Exactly 32 core_rnd_en cycles with core_round 0..31.
//    -> First out_valid 34 cycles after the last input accept.
//  3 out_ready=0 for 5 cycles on nibble 3. -> cipher is held at 'b' and out_valid stays 1.
//    -> No skipped or repeated nibble, and done_final is delayed by 5 cycles.
//  4 After 3 beats, a new beat with start=1, key=AA and pt=F arrives, followed by 7 beats.
//    -> key_word[63:56]=AA and blk_word[31:28]=F. The 3 stale beats are absent.
//  5 Beats with start=0 in idle (beat_cnt 0). -> No capture and beat_cnt stays 0.
//  6 reset driven low during ROUND (core_round=10). -> All outputs are 0 asynchronously and state is LOAD.
//    -> A following clean frame reproduces the result of scenario 1.

Source files
------------

// File: rtl/simon_frame_sequencer_if.sv
// ---------------------------------------------------------------------------
// simon_frame_sequencer_if
// Handshake bundle between the chip pads and the Simon frame sequencer.
//
// Input stream (pads -> sequencer):
//   start     frame marker, qualifies beat 0 of a frame
//   in_valid  key/plaintext beat valid
//   in_ready  sequencer accepts a beat this cycle
//   key       KW-bit key beat, big-endian across the frame
//   Plaintxt  PW-bit plaintext beat, big-endian across the frame
// Output stream (sequencer -> pads):
//   out_valid cipher nibble valid
//   out_ready downstream accepts the nibble
//   cipher    PW-bit cipher nibble, most significant nibble first
//
// Modports: master = pad side / environment, slave = sequencer.
// ---------------------------------------------------------------------------
interface simon_frame_sequencer_if #(
    parameter int KW = 8,
    parameter int PW = 4
) ();
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic [KW-1:0] key;
    logic [PW-1:0] Plaintxt;
    logic          out_valid;
    logic          out_ready;
    logic [PW-1:0] cipher;

    modport master (
        output start, in_valid, key, Plaintxt, out_ready,
        input  in_ready, out_valid, cipher
    );

    modport slave (
        input  start, in_valid, key, Plaintxt, out_ready,
        output in_ready, out_valid, cipher
    );
endinterface

// File: rtl/simon_frame_sequencer.sv
// ---------------------------------------------------------------------------
// simon_frame_sequencer
// Controller in front of the Simon 32/64 round datapath. Collects a frame of
// BEATS key bytes and plaintext nibbles, loads the round core, issues ROUNDS
// round enables, captures the ciphertext and streams it back out nibble by
// nibble, most significant first.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous reset, active low (0 = reset)
//   bus          slave side of simon_frame_sequencer_if (input beats and
//                cipher output stream)
//   key_word     assembled key to the round core (KW*BEATS bits)
//   blk_word     assembled plaintext block to the round core (PW*BEATS bits)
//   core_load    one-cycle load strobe to the round core
//   core_rnd_en  round core advances one round
//   core_round   index of the round being executed
//   core_ct      ciphertext from the round core
//   done_final   one-cycle pulse when the last cipher nibble has been taken
//   busy         high in every state except LOAD
// ---------------------------------------------------------------------------
module simon_frame_sequencer #(
    parameter int KW     = 8,
    parameter int PW     = 4,
    parameter int BEATS  = 8,
    parameter int ROUNDS = 32,
    parameter int RW     = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    simon_frame_sequencer_if.slave bus,
    output logic [KW*BEATS-1:0]   key_word,
    output logic [PW*BEATS-1:0]   blk_word,
    output logic                  core_load,
    output logic                  core_rnd_en,
    output logic [RW-1:0]         core_round,
    input  logic [PW*BEATS-1:0]   core_ct,
    output logic                  done_final,
    output logic                  busy
);

    localparam int KWW = KW * BEATS;
    localparam int BWW = PW * BEATS;
    localparam int CW  = (BEATS > 1) ? $clog2(BEATS) : 1;

    typedef enum logic [2:0] {
        LOAD,
        KICK,
        ROUND,
        CAPTURE,
        DRAIN
    } state_t;

    state_t          state;
    state_t          next_state;
    logic [CW-1:0]   beat_cnt;
    logic [RW-1:0]   round_cnt;
    logic [BWW-1:0]  shreg;

    logic            in_acc;
    logic            out_acc;
    logic            last_beat;
    logic            last_round;

    assign in_acc     = bus.in_valid && bus.in_ready;
    assign out_acc    = bus.out_valid && bus.out_ready;
    assign last_beat  = (beat_cnt == CW'(BEATS - 1));
    assign last_round = (round_cnt == RW'(ROUNDS - 1));

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= LOAD;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic. A start beat on the last slot restarts the frame
    // rather than completing it, so only a non-start beat can close a frame.
    always_comb begin
        next_state = state;
        unique case (state)
            LOAD:    if (in_acc && !bus.start && last_beat) next_state = KICK;
            KICK:    next_state = ROUND;
            ROUND:   if (last_round) next_state = CAPTURE;
            CAPTURE: next_state = DRAIN;
            DRAIN:   if (out_acc && last_beat) next_state = LOAD;
            default: next_state = LOAD;
        endcase
    end

    // Output decode. in_ready is gated by reset so that every output reads 0
    // while reset is held, even though the FSM already sits in LOAD.
    always_comb begin
        bus.in_ready  = (state == LOAD) && reset;
        bus.out_valid = (state == DRAIN);
        core_load     = (state == KICK);
        core_rnd_en   = (state == ROUND);
        busy          = (state != LOAD);
    end

    assign bus.cipher = shreg[BWW-1 -: PW];
    assign core_round = round_cnt;

    // Datapath. beat_cnt counts input beats in LOAD and is reused to count
    // drained nibbles in DRAIN; it is always back at 0 between those uses.
    // A start beat reloads the words from scratch so that no stale beat of
    // an abandoned frame survives in the low bits.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            key_word   <= '0;
            blk_word   <= '0;
            beat_cnt   <= '0;
            round_cnt  <= '0;
            shreg      <= '0;
            done_final <= 1'b0;
        end else begin
            done_final <= 1'b0;
            unique case (state)
                LOAD: begin
                    if (in_acc) begin
                        if (bus.start) begin
                            key_word <= KWW'(bus.key);
                            blk_word <= BWW'(bus.Plaintxt);
                            beat_cnt <= CW'(1);
                        end else if (beat_cnt != '0) begin
                            key_word <= {key_word[KWW-KW-1:0], bus.key};
                            blk_word <= {blk_word[BWW-PW-1:0], bus.Plaintxt};
                            beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
                        end
                    end
                end
                ROUND: begin
                    round_cnt <= last_round ? '0 : round_cnt + RW'(1);
                end
                CAPTURE: begin
                    shreg <= core_ct;
                end
                DRAIN: begin
                    if (out_acc) begin
                        shreg    <= {shreg[BWW-PW-1:0], PW'(0)};
                        beat_cnt <= last_beat ? '0 : beat_cnt + CW'(1);
                        if (last_beat) begin
                            done_final <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_simon_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_simon_frame_sequencer
// Self-checking bench for simon_frame_sequencer. The load phase is driven from
// a table of {inputs, expected outputs}; whole-frame behaviour (rounds,
// latency, drain, stall, reset mid-frame) is covered by hand-written
// sequences. The round core is stood in for by a constant ciphertext.
// ---------------------------------------------------------------------------
module tb_simon_frame_sequencer;

    localparam int KW     = 8;
    localparam int PW     = 4;
    localparam int BEATS  = 8;
    localparam int ROUNDS = 32;
    localparam int RW     = 5;

    localparam logic [63:0] S1_KEY = 64'h1918111009080100;
    localparam logic [31:0] S1_PT  = 32'h65656877;
    localparam logic [31:0] S1_CT  = 32'hc69be9bb;

    logic                clk;
    logic                reset;
    logic [KW*BEATS-1:0] key_word;
    logic [PW*BEATS-1:0] blk_word;
    logic                core_load;
    logic                core_rnd_en;
    logic [RW-1:0]       core_round;
    logic [PW*BEATS-1:0] core_ct;
    logic                done_final;
    logic                busy;

    int tests_run    = 0;
    int tests_failed = 0;

    simon_frame_sequencer_if #(.KW(KW), .PW(PW)) bus_if ();

    simon_frame_sequencer #(
        .KW(KW), .PW(PW), .BEATS(BEATS), .ROUNDS(ROUNDS), .RW(RW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus_if),
        .key_word   (key_word),
        .blk_word   (blk_word),
        .core_load  (core_load),
        .core_rnd_en(core_rnd_en),
        .core_round (core_round),
        .core_ct    (core_ct),
        .done_final (done_final),
        .busy       (busy)
    );

    // 10 ns clock, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic        in_valid;
        logic [7:0]  key;
        logic [3:0]  pt;
        logic [63:0] exp_kw;
        logic [31:0] exp_bw;
        logic        exp_load;
        logic        exp_rdy;
    } vec_t;

    vec_t vecs[14];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Drive one input beat, clock it in, and settle 1 ns past the edge.
    task automatic applyStimulus(input logic st, input logic vld, input logic [7:0] k, input logic [3:0] p);
        bus_if.start    = st;
        bus_if.in_valid = vld;
        bus_if.key      = k;
        bus_if.Plaintxt = p;
        @(posedge clk);
        #1;
    endtask

    task automatic load_frame(input logic [63:0] kw, input logic [31:0] bw);
        for (int b = 0; b < BEATS; b++) begin
            applyStimulus(b == 0, 1'b1, 8'(kw >> (56 - 8 * b)), 4'(bw >> (28 - 4 * b)));
        end
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
    endtask

    // Entered 1 ns after the edge that accepted the last input beat (KICK).
    // Checks the load, the round sequence, latency, drain order, an optional
    // stall on one nibble, and the done_final pulse.
    task automatic run_core(input logic [63:0] ekw, input logic [31:0] ebw, input logic [31:0] ct,
                            input int stall_idx, input int stall_len);
        int k;
        int rnd_seen;
        int first_ov;
        int i;
        int cyc;
        int stalled;
        logic [3:0] en;
        k        = 0;
        rnd_seen = 0;
        first_ov = 0;
        core_ct  = ct;
        bus_if.out_ready = 1'b0;
        checkOutput("core_load", core_load, 1);
        checkOutput("key_word_at_load", key_word, ekw);
        checkOutput("blk_word_at_load", blk_word, ebw);
        // Beats offered outside LOAD must be ignored.
        bus_if.start    = 1'b1;
        bus_if.in_valid = 1'b1;
        bus_if.key      = 8'h5A;
        bus_if.Plaintxt = 4'h5;
        while (first_ov == 0 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
            if (core_rnd_en) begin
                checkOutput("core_round", core_round, 64'(rnd_seen));
                rnd_seen++;
            end
            if (bus_if.out_valid) first_ov = k;
        end
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
        checkOutput("rnd_en_cycles", 64'(rnd_seen), 64'(ROUNDS));
        checkOutput("latency", 64'(first_ov), 64'(ROUNDS + 2));
        checkOutput("key_word_held", key_word, ekw);
        checkOutput("blk_word_held", blk_word, ebw);
        checkOutput("in_ready_busy", bus_if.in_ready, 0);

        i       = 0;
        cyc     = 0;
        stalled = 0;
        while (i < BEATS && cyc < 100) begin
            en = 4'(ct >> (28 - 4 * i));
            checkOutput("out_valid", bus_if.out_valid, 1);
            checkOutput("cipher", bus_if.cipher, en);
            checkOutput("done_early", done_final, 0);
            if (i == stall_idx && stalled < stall_len) begin
                bus_if.out_ready = 1'b0;
                stalled++;
            end else begin
                bus_if.out_ready = 1'b1;
                i++;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        checkOutput("done_final", done_final, 1);
        checkOutput("in_ready_after", bus_if.in_ready, 1);
        checkOutput("drain_cycles", 64'(cyc), 64'(BEATS + stall_len));
        bus_if.out_ready = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("done_pulse_width", done_final, 0);
        checkOutput("busy_idle", busy, 0);
    endtask

    initial begin
        int g;
        reset            = 1'b0;
        bus_if.start     = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.key       = '0;
        bus_if.Plaintxt  = '0;
        bus_if.out_ready = 1'b0;
        core_ct          = '0;

        // Load-phase table: dropped beats, start without valid, restart
        // after three beats, then the remaining seven beats of the frame.
        vecs[0]  = '{1'b0, 1'b1, 8'h55, 4'h3, 64'h0, 32'h0, 1'b0, 1'b1};
        vecs[1]  = '{1'b0, 1'b1, 8'h66, 4'h2, 64'h0, 32'h0, 1'b0, 1'b1};
        vecs[2]  = '{1'b1, 1'b0, 8'h77, 4'h1, 64'h0, 32'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b1, 1'b1, 8'h01, 4'h1, 64'h01, 32'h1, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h02, 4'h2, 64'h0102, 32'h12, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h03, 4'h3, 64'h010203, 32'h123, 1'b0, 1'b1};
        vecs[6]  = '{1'b1, 1'b1, 8'hAA, 4'hF, 64'hAA, 32'hF, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'hBB, 4'hE, 64'hAABB, 32'hFE, 1'b0, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'hCC, 4'hD, 64'hAABBCC, 32'hFED, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'hDD, 4'hC, 64'hAABBCCDD, 32'hFEDC, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'hEE, 4'hB, 64'hAABBCCDDEE, 32'hFEDCB, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h12, 4'hA, 64'hAABBCCDDEE12, 32'hFEDCBA, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b1, 8'h34, 4'h9, 64'hAABBCCDDEE1234, 32'hFEDCBA9, 1'b0, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 8'h56, 4'h8, 64'hAABBCCDDEE123456, 32'hFEDCBA98, 1'b1, 1'b0};

        // Reset values with reset held low from time 0.
        #2;
        checkOutput("rst_in_ready", bus_if.in_ready, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_out_valid", bus_if.out_valid, 0);
        checkOutput("rst_core_load", core_load, 0);
        checkOutput("rst_rnd_en", core_rnd_en, 0);
        checkOutput("rst_core_round", core_round, 0);
        checkOutput("rst_key_word", key_word, 0);
        checkOutput("rst_blk_word", blk_word, 0);
        checkOutput("rst_cipher", bus_if.cipher, 0);
        checkOutput("rst_done", done_final, 0);
        #10;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("idle_in_ready", bus_if.in_ready, 1);

        for (int v = 0; v < 14; v++) begin
            applyStimulus(vecs[v].start, vecs[v].in_valid, vecs[v].key, vecs[v].pt);
            checkOutput($sformatf("vec%0d_key_word", v), key_word, vecs[v].exp_kw);
            checkOutput($sformatf("vec%0d_blk_word", v), 64'(blk_word), 64'(vecs[v].exp_bw));
            checkOutput($sformatf("vec%0d_core_load", v), core_load, vecs[v].exp_load);
            checkOutput($sformatf("vec%0d_in_ready", v), bus_if.in_ready, vecs[v].exp_rdy);
        end
        bus_if.start    = 1'b0;
        bus_if.in_valid = 1'b0;
        run_core(64'hAABBCCDDEE123456, 32'hFEDCBA98, 32'h13579bdf, -1, 0);

        // Reference frame, no stall.
        load_frame(S1_KEY, S1_PT);
        run_core(S1_KEY, S1_PT, S1_CT, -1, 0);

        // Reference frame with a 5-cycle stall on nibble 3 ('b').
        load_frame(S1_KEY, S1_PT);
        run_core(S1_KEY, S1_PT, S1_CT, 3, 5);

        // Reset asserted in the middle of ROUND.
        load_frame(S1_KEY, S1_PT);
        core_ct = S1_CT;
        g = 0;
        while (core_round !== 5'd10 && g < 100) begin
            @(posedge clk);
            #1;
            g++;
        end
        checkOutput("reach_round10", core_round, 10);
        #2;
        reset = 1'b0;
        #1;
        checkOutput("mid_rst_rnd_en", core_rnd_en, 0);
        checkOutput("mid_rst_round", core_round, 0);
        checkOutput("mid_rst_busy", busy, 0);
        checkOutput("mid_rst_in_ready", bus_if.in_ready, 0);
        checkOutput("mid_rst_key_word", key_word, 0);
        checkOutput("mid_rst_blk_word", blk_word, 0);
        checkOutput("mid_rst_out_valid", bus_if.out_valid, 0);
        @(posedge clk);
        #3;
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("post_rst_in_ready", bus_if.in_ready, 1);
        checkOutput("post_rst_done", done_final, 0);
        checkOutput("post_rst_round", core_round, 0);

        load_frame(S1_KEY, S1_PT);
        run_core(S1_KEY, S1_PT, S1_CT, -1, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
